gpio_pad_ctrl: RTL

- Parametrised GPIO pad controller between the SoC GPIO peripheral (read/write/writeEnable buses) and the FPGA pad buffers (IOBUF O/I/T).
- Replaces the plain per-pin tristate hookup used today.
- Adds these functions:
  - registered output/tristate drive;
  - multi-stage input synchronisation;
  - per-channel debounce;
  - per-channel rising/falling edge interrupts with sticky pending bits and a combined irq.
- Sits in the board top level, one instance per GPIO bank.

---
 rtl/gpio_pad_ctrl_pkg.sv | 23 ++
 rtl/gpio_pad_ctrl_if.sv | 27 ++
 rtl/gpio_pad_chan.sv | 96 +++++++++
 rtl/gpio_pad_ctrl.sv | 61 ++++++
 4 files changed

// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared definitions for the GPIO pad controller: pad reset values, the widest
// supported bank and the legal range of input synchroniser depths.
package gpio_pad_ctrl_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] bank_t;

    // Pads come out of reset as undriven inputs with a low output value.
    localparam bank_t PAD_T_RESET = '1;
    localparam bank_t PAD_O_RESET = '0;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Fewer than two flops is not a synchroniser; more than four only adds latency.
    function automatic int unsigned sync_stages_clamp(input int unsigned stages);
        if (stages < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (stages > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return stages;
    endfunction

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// SoC-side GPIO bus of one pad bank: drive values, read-back and interrupts.
interface gpio_pad_ctrl_if
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] pins_write;
    logic [WIDTH-1:0] pins_writeEnable;
    logic [WIDTH-1:0] pins_read;
    logic [WIDTH-1:0] irq_rise_en;
    logic [WIDTH-1:0] irq_fall_en;
    logic [WIDTH-1:0] irq_clear;
    logic [WIDTH-1:0] irq_pending;
    logic             irq;

    // SoC GPIO peripheral side.
    modport master (
        output pins_write, pins_writeEnable, irq_rise_en, irq_fall_en, irq_clear,
        input  pins_read, irq_pending, irq
    );

    // Pad controller side.
    modport slave (
        input  pins_write, pins_writeEnable, irq_rise_en, irq_fall_en, irq_clear,
        output pins_read, irq_pending, irq
    );
endinterface

// File: rtl/gpio_pad_chan.sv
// One GPIO input channel: synchroniser, optional debounce (GPIO_PAD_DEBOUNCE_EN),
// registered read value, edge detection and sticky pending bit.
module gpio_pad_chan
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic io_clock,
    input  logic io_reset,
    input  logic pad,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clear,
    output logic read,
    output logic pending,
    output logic pending_next
);
    localparam int unsigned STAGES = sync_stages_clamp(SYNC_STAGES);

    logic [STAGES-1:0] sync_q;
    logic              sync;
    logic              stable;
    logic              read_q, read_prev_q;
    logic              pending_q, pending_d;
    logic              rise, fall;

    // Plain flop chain; nothing may sit between the stages.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], pad};
    end

    assign sync = sync_q[STAGES-1];

`ifdef GPIO_PAD_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = sync;
            else                                      cnt_d    = cnt_q + 1'b1;
        end
    end

    // Debounce state.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign stable = sync;
`endif

    // Edges are taken between the read value and its one-cycle-old copy.
    assign rise = read_q & ~read_prev_q;
    assign fall = ~read_q & read_prev_q;

    // Set beats clear so an edge landing on a clear cycle is never lost.
    always_comb begin
        pending_d = (pending_q & ~clear) | (rise & rise_en) | (fall & fall_en);
    end

    // Read value, its delayed copy and the sticky pending bit.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            read_q      <= 1'b0;
            read_prev_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            read_q      <= stable;
            read_prev_q <= read_q;
            pending_q   <= pending_d;
        end
    end

    assign read         = read_q;
    assign pending      = pending_q;
    assign pending_next = pending_d;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank controller: registered pad drive, per-channel conditioned inputs
// and a combined interrupt. Debounce is built when GPIO_PAD_DEBOUNCE_EN is defined.
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             io_clock,
    input  logic             io_reset,
    gpio_pad_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t
);
    logic [WIDTH-1:0] pad_o_q, pad_t_q;
    logic [WIDTH-1:0] read_vec, pending_vec, pending_next_vec;
    logic             irq_q;

    // Pad drive registers; pad_t resets to all-inputs so release cannot glitch a driver on.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            pad_o_q <= PAD_O_RESET[WIDTH-1:0];
            pad_t_q <= PAD_T_RESET[WIDTH-1:0];
        end else begin
            pad_o_q <= bus.pins_write;
            pad_t_q <= ~bus.pins_writeEnable;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gen_chan
        gpio_pad_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .io_clock     (io_clock),
            .io_reset     (io_reset),
            .pad          (pad_i[i]),
            .rise_en      (bus.irq_rise_en[i]),
            .fall_en      (bus.irq_fall_en[i]),
            .clear        (bus.irq_clear[i]),
            .read         (read_vec[i]),
            .pending      (pending_vec[i]),
            .pending_next (pending_next_vec[i])
        );
    end

    // Reduce the next pending state so irq rises together with its pending bit.
    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) irq_q <= 1'b0;
        else          irq_q <= |pending_next_vec;
    end

    assign pad_o           = pad_o_q;
    assign pad_t           = pad_t_q;
    assign bus.pins_read   = read_vec;
    assign bus.irq_pending = pending_vec;
    assign bus.irq         = irq_q;

endmodule
